rc4_prga_decryptor: RTL and testbench
=====================================

Name: rc4_prga_decryptor

Overview:
- Downstream consumer of the 32-byte encrypted message captured from ROM; runs once per candidate key, after key scheduling has finished filling the S memory.
- Runs the RC4 pseudo-random generation loop against the on-chip S RAM, XORs each keystream byte with the matching encrypted byte, and writes plaintext to the decrypted-message RAM.
- Flags whether every plaintext byte is a lowercase letter or a space; the key-search controller uses this flag to accept or reject the key.

Parameters:
- MSG_LEN, 32, number of message bytes processed; must be ≤ 32 and match the encrypted input array depth.

Ports:
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  level; rising edge (registered, edge-detected internally) launches one decryption pass
- encrypted_data  in  8 x 32 (unpacked array [31:0] of [7:0])  encrypted message bytes, stable for the whole pass
- s_q  in  8  S RAM read data
- s_address  out  8  S RAM address
- s_data  out  8  S RAM write data
- s_wren  out  1  S RAM write enable
- d_address  out  5  decrypted RAM address (byte index k)
- d_data  out  8  decrypted RAM write data
- d_wren  out  1  decrypted RAM write enable
- done  out  1  pass finished (success or abort)
- key_valid  out  1  meaningful only while done=1; 1 = all MSG_LEN bytes are valid characters

Behaviour:
- **RAM timing:** the RAM samples the address and write enable at a clock edge. Read data is valid in the following cycle and is captured by this block at the next edge, giving one full wait cycle per read.
- **Reset:** done=0, key_valid=0, s_wren=0, d_wren=0, all addresses and data = 0, i=j=k=0, state IDLE.
  - Reset mid-pass aborts immediately; RAM contents are left as-is.
- **Registers:**
  - i, j, k: 8, 8, 6 bits.
  - si, sj, f: 8-bit captures.
  - All index arithmetic is mod 256 (natural 8-bit wrap).
- **States and per-byte sequence (9 cycles per byte):**
  - IDLE: on start rising edge → i<=1, j<=0, k<=0, done<=0, key_valid<=0, go READ_SI.
  - READ_SI: s_address=i.
  - CAP_SI: si<=s_q, j<=j+s_q.
  - READ_SJ: s_address=j (updated value).
  - CAP_SJ: sj<=s_q.
  - WR_SI: s_address=i, s_data=sj, s_wren=1.
  - WR_SJ: s_address=j, s_data=si, s_wren=1.
  - READ_F: s_address=si+sj, using the pre-swap captured values.
  - CAP_F: f<=s_q.
  - WR_D: d_address=k, d_data=f^encrypted_data[k], d_wren=1; the character check runs on this d_data value.
    - Invalid byte → DONE with key_valid=0.
    - Valid byte and k==MSG_LEN-1 → DONE with key_valid=1.
    - Otherwise → k<=k+1, i<=i+1, go READ_SI.
  - DONE: done=1 and key_valid held; a new start rising edge restarts the pass (clears done and key_valid the next cycle). start held high does not retrigger.
- **Valid character:** 8'h61..8'h7A inclusive, or 8'h20.
- **Write enables:** s_wren and d_wren are high only in their write states; exactly one RAM write per write state.
- **i==j:** both swap writes hit the same address; the second write (si) leaves the value unchanged. Correct by construction, no special case.
- **Abort on invalid byte:** the invalid byte is still written to the decrypted RAM; no further bytes are written.
- **Latency:** with the start edge seen at edge 0, a full valid pass enters DONE at edge 1+9*MSG_LEN (289 for 32 bytes). done and key_valid are registered and change on that edge.

Test Plan:
- **Identity S, first byte:** S preloaded s[x]=x, enc[0]=8'h63, start → first S reads at addresses 1,1; swap writes 1←1, 1←1; f read at address 2; d_address=0, d_data=8'h61, key_valid unaffected.
- **Full valid pass:** identity S with enc[] built from a reference RC4 model so that plaintext = "abcdefghijklmnopqrstuvwxyz      " → 32 d_wren pulses; done at edge 289; key_valid=1; final S matches the model.
- **Early abort:** identity S, enc[0]=8'h00 → d_data=8'h02 written to address 0; done at edge 10; key_valid=0; no further d_wren or s_wren.
- **Boundary characters:** plaintext bytes 8'h20, 8'h61 and 8'h7A pass; a byte of 8'h60, 8'h7B or 8'h40 at k=5 aborts with key_valid=0 after exactly 6 d_wren pulses.
- **Reset mid-pass:** assert reset at edge 50 → next cycle done=0, all wren=0, state IDLE; a later start runs a clean pass with i starting at 1 and j at 0.
- **Restart from DONE:** start held high after done → no retrigger; deassert, then reassert → done drops and a new pass runs on the current S contents.

Source files
------------

// File: rtl/rc4_prga_decryptor.sv
// RC4 keystream generator and decryptor: walks the S RAM with the PRGA swap loop,
// XORs each keystream byte with the ROM message and flags all-printable plaintext.
module rc4_prga_decryptor #(
  parameter int MSG_LEN = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] encrypted_data [31:0],
  input  logic [7:0] s_q,
  output logic [7:0] s_address,
  output logic [7:0] s_data,
  output logic       s_wren,
  output logic [4:0] d_address,
  output logic [7:0] d_data,
  output logic       d_wren,
  output logic       done,
  output logic       key_valid,
  output logic [3:0] state_dbg
);

  // Protocol: a rising edge on the start level (from IDLE or DONE) launches one pass;
  // done rises when the pass ends and stays high, with key_valid meaningful, until
  // the next rising edge of start. Holding start high never relaunches.

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    READ_SI = 4'd1,
    CAP_SI  = 4'd2,
    READ_SJ = 4'd3,
    CAP_SJ  = 4'd4,
    WR_SI   = 4'd5,
    WR_SJ   = 4'd6,
    READ_F  = 4'd7,
    CAP_F   = 4'd8,
    WR_D    = 4'd9,
    DONE    = 4'd10
  } state_t;

  state_t     state;
  state_t     state_nx;

  logic [7:0] i;
  logic [7:0] j;
  logic [5:0] k;
  logic [7:0] si;
  logic [7:0] sj;
  logic [7:0] f;
  logic       start_q;
  logic       start_q2;

  logic       start_rise;
  logic [7:0] f_addr;
  logic [7:0] plain;
  logic       char_ok;
  logic       last_byte;

  assign start_rise = start_q & ~start_q2;
  // Keystream index uses the pre-swap captures; the sum is unchanged by the swap.
  assign f_addr     = si + sj;
  assign plain      = f ^ encrypted_data[k[4:0]];
  assign char_ok    = ((plain >= 8'h61) && (plain <= 8'h7a)) || (plain == 8'h20);
  assign last_byte  = (k == 6'(MSG_LEN - 1));
  assign state_dbg  = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      i         <= 8'd0;
      j         <= 8'd0;
      k         <= 6'd0;
      si        <= 8'd0;
      sj        <= 8'd0;
      f         <= 8'd0;
      done      <= 1'b0;
      key_valid <= 1'b0;
      start_q   <= 1'b0;
      start_q2  <= 1'b0;
    end else begin
      start_q  <= start;
      start_q2 <= start_q;
      state    <= state_nx;
      case (state)
        IDLE, DONE: begin
          if (start_rise) begin
            i         <= 8'd1;
            j         <= 8'd0;
            k         <= 6'd0;
            done      <= 1'b0;
            key_valid <= 1'b0;
          end
        end
        CAP_SI: begin
          si <= s_q;
          j  <= j + s_q;
        end
        CAP_SJ: sj <= s_q;
        CAP_F:  f  <= s_q;
        WR_D: begin
          if (!char_ok) begin
            done      <= 1'b1;
            key_valid <= 1'b0;
          end else if (last_byte) begin
            done      <= 1'b1;
            key_valid <= 1'b1;
          end else begin
            k <= k + 6'd1;
            i <= i + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx  = state;
    s_address = 8'd0;
    s_data    = 8'd0;
    s_wren    = 1'b0;
    d_address = 5'd0;
    d_data    = 8'd0;
    d_wren    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start_rise) state_nx = READ_SI;
      end
      READ_SI: begin
        s_address = i;
        state_nx  = CAP_SI;
      end
      CAP_SI:  state_nx = READ_SJ;
      READ_SJ: begin
        s_address = j;
        state_nx  = CAP_SJ;
      end
      CAP_SJ:  state_nx = WR_SI;
      WR_SI: begin
        s_address = i;
        s_data    = sj;
        s_wren    = 1'b1;
        state_nx  = WR_SJ;
      end
      // When i==j this rewrites the same location with its original value.
      WR_SJ: begin
        s_address = j;
        s_data    = si;
        s_wren    = 1'b1;
        state_nx  = READ_F;
      end
      READ_F: begin
        s_address = f_addr;
        state_nx  = CAP_F;
      end
      CAP_F:   state_nx = WR_D;
      WR_D: begin
        d_address = k[4:0];
        d_data    = plain;
        d_wren    = 1'b1;
        state_nx  = (!char_ok || last_byte) ? DONE : READ_SI;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rc4_prga_decryptor.sv
// Bench for rc4_prga_decryptor: S RAM model, textbook RC4 reference, and a
// scoreboard checking every S/D RAM write, done latency and key_valid.
module tb_rc4_prga_decryptor;

  localparam int MSG_LEN = 32;
  localparam logic [3:0] IDLE_CODE = 4'd0;

  typedef logic [7:0] sbox_t [256];
  typedef logic [7:0] msg_t [32];

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] encrypted_data [31:0];
  logic [7:0] s_q;
  logic [7:0] s_address;
  logic [7:0] s_data;
  logic       s_wren;
  logic [4:0] d_address;
  logic [7:0] d_data;
  logic       d_wren;
  logic       done;
  logic       key_valid;
  logic [3:0] state_dbg;

  always #5 clk = ~clk;

  rc4_prga_decryptor #(.MSG_LEN(MSG_LEN)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .encrypted_data (encrypted_data),
    .s_q            (s_q),
    .s_address      (s_address),
    .s_data         (s_data),
    .s_wren         (s_wren),
    .d_address      (d_address),
    .d_data         (d_data),
    .d_wren         (d_wren),
    .done           (done),
    .key_valid      (key_valid),
    .state_dbg      (state_dbg)
  );

  // S RAM: synchronous read, data available the cycle after the address edge.
  sbox_t mem;
  sbox_t load_img;
  logic  load_req = 1'b0;
  always @(posedge clk) begin
    if (load_req) mem <= load_img;
    else if (s_wren) mem[s_address] <= s_data;
    s_q <= mem[s_address];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  logic [15:0] s_exp_q[$];
  logic [12:0] d_exp_q[$];
  logic [0:0]  kv_exp_q[$];
  logic [15:0] lat_exp_q[$];
  sbox_t ref_s;
  logic  last_kv = 1'b0;
  int    start_cyc = 0;
  int    pass_base = 0;
  int    pass_cnt = 0;
  int    d_pulses = 0;
  logic  done_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name, input logic [31:0] act);
    checks++;
    failures++;
    $display("FAIL %s actual=%0h required=nothing", name, act);
  endtask

  function automatic bit is_char(input logic [7:0] b);
    return ((b >= 8'h61) && (b <= 8'h7a)) || (b == 8'h20);
  endfunction

  // Monitor: pops expectations whenever the DUT writes a RAM or raises done.
  always @(negedge clk) begin
    if (reset) begin
      done_prev <= 1'b0;
    end else begin
      if (s_wren) begin
        if (s_exp_q.size() == 0) note_fail("s_write_extra", {s_address, s_data});
        else check("s_write", {s_address, s_data}, s_exp_q.pop_front());
      end
      if (d_wren) begin
        d_pulses <= d_pulses + 1;
        if (d_exp_q.size() == 0) note_fail("d_write_extra", {d_address, d_data});
        else check("d_write", {d_address, d_data}, d_exp_q.pop_front());
      end
      if (done && (s_wren || d_wren)) note_fail("write_while_done", {s_wren, d_wren});
      if (done && !done_prev) begin
        pass_cnt <= pass_cnt + 1;
        if (lat_exp_q.size() == 0) begin
          note_fail("done_unexpected", cyc - start_cyc);
        end else begin
          check("done_latency", cyc - start_cyc, lat_exp_q.pop_front());
          check("key_valid", key_valid, kv_exp_q.pop_front());
          check("d_writes_missing", d_exp_q.size(), 0);
          check("s_writes_missing", s_exp_q.size(), 0);
        end
      end
      done_prev <= done;
    end
  end

  // Textbook RC4 PRGA over a copy of ref_s. With commit set it stops after the
  // first non-text byte, queues every expected write and keeps the new S.
  task automatic rc4_model(input msg_t enc, input bit commit, output msg_t ks);
    sbox_t s;
    logic [7:0] ii, jj, t, idx, p;
    bit ok;
    int n;
    s = ref_s;
    ii = 8'd0;
    jj = 8'd0;
    ok = 1'b1;
    n = 0;
    ks = '{default: 8'h00};
    for (int k = 0; k < MSG_LEN && ok; k++) begin
      ii = ii + 8'd1;
      jj = jj + s[ii];
      t = s[ii];
      s[ii] = s[jj];
      s[jj] = t;
      idx = s[ii] + s[jj];
      ks[k] = s[idx];
      if (commit) begin
        p = ks[k] ^ enc[k];
        s_exp_q.push_back({ii, s[ii]});
        s_exp_q.push_back({jj, s[jj]});
        d_exp_q.push_back({5'(k), p});
        ok = is_char(p);
        n = k + 1;
      end
    end
    if (commit) begin
      ref_s = s;
      last_kv = ok;
      kv_exp_q.push_back(ok);
      lat_exp_q.push_back(16'(1 + 9 * n));
    end
  endtask

  task automatic enc_for(input msg_t plain, output msg_t enc);
    msg_t ks, zero;
    zero = '{default: 8'h00};
    rc4_model(zero, 1'b0, ks);
    for (int k = 0; k < 32; k++) enc[k] = plain[k] ^ ks[k];
  endtask

  task automatic make_alpha(output msg_t p);
    for (int k = 0; k < 32; k++) p[k] = (k < 26) ? 8'(8'h61 + k) : 8'h20;
  endtask

  task automatic load_s(input bit identity);
    sbox_t img;
    int r;
    logic [7:0] t;
    for (int x = 0; x < 256; x++) img[x] = 8'(x);
    if (!identity) begin
      for (int x = 255; x > 0; x--) begin
        r = $urandom_range(x, 0);
        t = img[x];
        img[x] = img[r];
        img[r] = t;
      end
    end
    load_img = img;
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    ref_s = img;
  endtask

  // Call right after a negedge; the next posedge is edge 0 of the pass.
  task automatic start_pass(input msg_t enc);
    msg_t ks;
    for (int k = 0; k < 32; k++) encrypted_data[k] = enc[k];
    rc4_model(enc, 1'b1, ks);
    pass_base = pass_cnt;
    start = 1'b1;
    start_cyc = cyc + 1;
  endtask

  task automatic wait_done(input int budget);
    int t = 0;
    while (pass_cnt == pass_base && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (pass_cnt == pass_base) begin
      note_fail("done_timeout", t);
      s_exp_q.delete();
      d_exp_q.delete();
      kv_exp_q.delete();
      lat_exp_q.delete();
    end
  endtask

  task automatic check_s();
    int diffs = 0;
    for (int x = 0; x < 256; x++) if (mem[x] !== ref_s[x]) diffs++;
    check("final_s_diffs", diffs, 0);
  endtask

  task automatic finish_pass(input int hold);
    int drops = 0;
    wait_done(400);
    check_s();
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (done !== 1'b1 || key_valid !== last_kv) drops++;
    end
    if (hold > 0) check("no_retrigger", drops, 0);
    start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic run_pass(input msg_t enc, input int hold);
    start_pass(enc);
    finish_pass(hold);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    msg_t plain, enc;
    logic [7:0] bad_set [3];
    logic [7:0] b;
    int base;
    int pos;

    for (int k = 0; k < 32; k++) encrypted_data[k] = 8'h00;
    bad_set[0] = 8'h60;
    bad_set[1] = 8'h7b;
    bad_set[2] = 8'h40;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_done", done, 0);
    check("rst_key_valid", key_valid, 0);
    check("rst_wren", {s_wren, d_wren}, 0);
    check("rst_addr", {s_address, 3'b000, d_address}, 0);
    check("rst_data", {s_data, d_data}, 0);
    check("rst_state", state_dbg, IDLE_CODE);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Identity S, full valid alphabet pass with first-byte access trace
    load_s(1'b1);
    make_alpha(plain);
    enc_for(plain, enc);
    check("id_enc0", enc[0], 8'h63);
    start_pass(enc);
    @(negedge clk);
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      if (n == 1 || n == 3 || (n >= 5 && n <= 7)) begin
        check($sformatf("id_trace_addr_%0d", n), s_address, (n == 7) ? 8'd2 : 8'd1);
        check($sformatf("id_trace_wren_%0d", n), s_wren, (n == 5 || n == 6) ? 1 : 0);
      end
      if (n == 5 || n == 6) check($sformatf("id_trace_data_%0d", n), s_data, 8'd1);
      if (n == 9) begin
        check("id_first_plain", {d_wren, 3'b000, d_address, d_data}, {1'b1, 3'b000, 5'd0, 8'h61});
        check("id_kv_untouched", key_valid, 0);
      end
    end
    finish_pass(0);

    // Early abort on the first byte
    load_s(1'b1);
    enc = '{default: 8'h00};
    base = d_pulses;
    run_pass(enc, 0);
    check("abort_d_pulses", d_pulses - base, 1);

    // Boundary characters pass; a bad byte at k=5 aborts after 6 writes
    for (int v = 0; v < 3; v++) begin
      make_alpha(plain);
      plain[0] = 8'h20;
      plain[1] = 8'h61;
      plain[2] = 8'h7a;
      plain[3] = 8'h61;
      plain[4] = 8'h20;
      plain[5] = bad_set[v];
      enc_for(plain, enc);
      base = d_pulses;
      run_pass(enc, 0);
      check($sformatf("bound_d_pulses_%0h", bad_set[v]), d_pulses - base, 6);
    end

    // Restart from DONE: held start does nothing, a fresh edge relaunches
    make_alpha(plain);
    enc_for(plain, enc);
    run_pass(enc, 20);
    plain[7] = 8'h7a;
    enc_for(plain, enc);
    start_pass(enc);
    repeat (2) @(negedge clk);
    check("restart_clears", {done, key_valid}, 0);
    finish_pass(0);

    // Reset at edge 50 of a pass, then a clean pass on whatever S was left
    make_alpha(plain);
    enc_for(plain, enc);
    start_pass(enc);
    while (cyc < start_cyc + 49) @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check("midrst_done", done, 0);
    check("midrst_wren", {s_wren, d_wren}, 0);
    check("midrst_state", state_dbg, IDLE_CODE);
    s_exp_q.delete();
    d_exp_q.delete();
    kv_exp_q.delete();
    lat_exp_q.delete();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    ref_s = mem;
    enc_for(plain, enc);
    run_pass(enc, 0);

    // Random S boxes with valid or single-fault plaintexts, and raw random data
    for (int r = 0; r < 5; r++) begin
      load_s(1'b0);
      for (int k = 0; k < 32; k++) begin
        pos = $urandom_range(0, 26);
        plain[k] = (pos == 26) ? 8'h20 : 8'(8'h61 + pos);
      end
      if (r % 2 == 1) begin
        pos = $urandom_range(0, 31);
        do b = 8'($urandom_range(0, 255)); while (is_char(b));
        plain[pos] = b;
      end
      enc_for(plain, enc);
      if (r == 4) for (int k = 0; k < 32; k++) enc[k] = 8'($urandom_range(0, 255));
      run_pass(enc, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
